lcd_driver_n: RTL and testbench
===============================

LCD_DRIVER_N -- requirements
Module: lcd_driver_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD display digits (>=1).
REQ-002 SHALL have parameter RING_SECS, default 60: maximum alarm ring duration in one_second ticks (>=1).
REQ-003 SHALL have port clock  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port one_second  input  1  single-cycle pulse, once per second.
REQ-006 SHALL have port alarm_time  input  4*NUM_DIGITS  alarm BCD digits; digit i at [4i+3:4i]; digit 0 least significant.
REQ-007 SHALL have port current_time  input  4*NUM_DIGITS  current-time BCD digits, same packing.
REQ-008 SHALL have port key  input  4*NUM_DIGITS  keypad-entered BCD digits, same packing.
REQ-009 SHALL have port show_a  input  1  level: display alarm time.
REQ-010 SHALL have port show_current_time  input  1  level: display key entry.
REQ-011 SHALL have port stop_alarm  input  1  level/pulse: silence ringing alarm.
REQ-012 SHALL have port display  output  8*NUM_DIGITS  ASCII code per digit, digit i at [8i+7:8i].
REQ-013 SHALL have port sound_a  output  1  registered alarm-sound enable.

Function
REQ-014 SHALL select source per cycle: show_current_time=1 -> key; else show_a=1 -> alarm_time; else current_time (show_current_time wins when both set).
REQ-015 SHALL encode each selected digit d: 0..9 -> 8'h30+d; 10..15 -> 8'h45 ('E').
REQ-016 SHALL register display; latency exactly 1 clock from input/select change to display change.
REQ-017 SHALL define match = 1 when all NUM_DIGITS digits of current_time equal alarm_time; key and display mode do not affect match.
REQ-018 SHALL register match each cycle (match_q); rise = match & ~match_q.
REQ-019 SHALL implement FSM with states IDLE, RINGING, HOLD.
REQ-020 IDLE: rise & ~stop_alarm -> RINGING, ring counter cleared to 0; rise & stop_alarm -> HOLD; else stay.
REQ-021 RINGING: stop_alarm -> HOLD; one_second pulse while counter == RING_SECS-1 -> HOLD; other one_second pulses increment counter.
REQ-022 Simultaneous stop_alarm and timeout in RINGING -> HOLD (single transition).
REQ-023 HOLD: ~match -> IDLE; else stay (no re-trigger within same matching minute).
REQ-024 sound_a SHALL be 1 exactly in cycles when FSM state register is RINGING (asserted cycle after rise).
REQ-025 Ring counter width SHALL be $clog2(RING_SECS+1); it SHALL never wrap.
REQ-026 alarm_time change making match rise while in IDLE SHALL trigger ringing exactly as a current_time change does.

Reset
REQ-027 reset=1 SHALL asynchronously force FSM to IDLE, counter 0, match_q 1, sound_a 0, display all 8'h30, blink phase 0.
REQ-028 match_q reset to 1 SHALL prevent ringing on the first cycle after reset if times already match.
REQ-029 Reset asserted mid-ring SHALL drop sound_a immediately, independent of clock.

Configuration
REQ-030 Macro LCD_DRIVER_N_BLINK_EN defined: blink phase register toggles on each one_second while show_current_time=1, cleared to 0 when show_current_time=0; phase 1 drives every display digit to 8'h20 (space).
REQ-031 Macro LCD_DRIVER_N_BLINK_EN undefined: no phase register; key entry displayed steadily per REQ-014/015.

Verification
REQ-032 NUM_DIGITS=4, current 12:29 -> 12:30 with alarm 12:30 -> sound_a=1 one cycle after match, stays 1.
REQ-033 Ringing, RING_SECS=3, three one_second pulses -> sound_a=0 after third pulse; stays 0 while time remains 12:30; alarm re-arms after time becomes 12:31.
REQ-034 Ringing, stop_alarm pulse coincident with final one_second -> single entry to HOLD, sound_a=0 next cycle, no re-ring.
REQ-035 show_a=1, show_current_time=1, key digits 4'hA,9,0,5 -> display 8'h45,8'h39,8'h30,8'h35 one cycle later; with BLINK_EN, spaces after one one_second pulse.
REQ-036 reset pulse asserted mid-ring between clock edges -> sound_a=0 and display 8'h30 before the next clock edge; no ring on release with times matching.

Source files
------------

// File: rtl/lcd_driver_n.sv
// lcd_driver_n: alarm-clock display and alarm sequencer.
// Each BCD digit of the selected source (key entry, alarm time or current
// time) is turned into an ASCII code and registered onto the display bus.
// An IDLE/RINGING/HOLD state machine sounds the alarm when the current time
// first reaches the alarm time. Ringing stops after RING_SECS one_second ticks
// or on stop_alarm. The alarm cannot re-trigger until the times differ again.
// Optional feature: define LCD_DRIVER_N_BLINK_EN to blink the key entry. The
// display then shows spaces on alternate seconds while show_current_time is set.
module lcd_driver_n #(
  parameter int NUM_DIGITS = 4,
  parameter int RING_SECS  = 60
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    one_second,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic [4*NUM_DIGITS-1:0] key,
  input  logic                    show_a,
  input  logic                    show_current_time,
  input  logic                    stop_alarm,
  output logic [8*NUM_DIGITS-1:0] display,
  output logic                    sound_a
);

  localparam int            CW       = $clog2(RING_SECS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RING_SECS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    match_q, match_d;
  logic                    sound_q, sound_d;
  logic [8*NUM_DIGITS-1:0] display_q, display_d;
  logic [4*NUM_DIGITS-1:0] sel_s;
  logic                    rise_s;
  logic                    blank_s;

  // BCD digit to ASCII; out-of-range codes read as 'E'
  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    logic [7:0] r;
    if (d <= 4'd9) begin
      r = 8'h30 + {4'h0, d};
    end else begin
      r = 8'h45;
    end
    return r;
  endfunction

`ifdef LCD_DRIVER_N_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase flips each second during key entry and rests at 0 otherwise
  always_comb begin
    blink_d = 1'b0;
    if (show_current_time) begin
      if (one_second) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
      end
    end else begin
      blink_d = 1'b0;
    end
  end

  // Blink phase register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blank_s = blink_d;
`else
  assign blank_s = 1'b0;
`endif

  // Source select (key entry has priority) and per-digit ASCII encoding
  always_comb begin
    sel_s     = current_time;
    display_d = '0;
    if (show_current_time) begin
      sel_s = key;
    end else if (show_a) begin
      sel_s = alarm_time;
    end else begin
      sel_s = current_time;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blank_s) begin
        display_d[8*i +: 8] = 8'h20;
      end else begin
        display_d[8*i +: 8] = enc_digit(sel_s[4*i +: 4]);
      end
    end
  end

  // Alarm match detection; rise only on the first matching cycle
  always_comb begin
    match_d = (current_time == alarm_time);
    rise_s  = match_d & ~match_q;
  end

  // Alarm FSM next-state, ring counter and sound enable
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          if (stop_alarm) begin
            state_d = HOLD;
          end else begin
            state_d = RINGING;
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RINGING: begin
        if (stop_alarm) begin
          state_d = HOLD;
        end else if (one_second) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = RINGING;
        end
      end
      HOLD: begin
        if (!match_d) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sound_d = (state_d == RINGING);
  end

  // State, counter, match history, sound and display registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      match_q   <= 1'b1;
      sound_q   <= 1'b0;
      display_q <= {NUM_DIGITS{8'h30}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      sound_q   <= sound_d;
      display_q <= display_d;
    end
  end

  assign display = display_q;
  assign sound_a = sound_q;

endmodule

// File: tb/tb_lcd_driver_n.sv
// tb_lcd_driver_n: table-driven display vectors plus hand-written alarm
// sequences, checked through an expectation queue on the falling clock edge.
module tb_lcd_driver_n;

  logic        clock = 1'b0;
  logic        reset;
  logic        one_second;
  logic [15:0] alarm_time;
  logic [15:0] current_time;
  logic [15:0] key;
  logic        show_a;
  logic        show_current_time;
  logic        stop_alarm;
  logic [31:0] display;
  logic        sound_a;

  int checks = 0;
  int errors = 0;

  lcd_driver_n #(.NUM_DIGITS(4), .RING_SECS(3)) dut (
    .clock             (clock),
    .reset             (reset),
    .one_second        (one_second),
    .alarm_time        (alarm_time),
    .current_time      (current_time),
    .key               (key),
    .show_a            (show_a),
    .show_current_time (show_current_time),
    .stop_alarm        (stop_alarm),
    .display           (display),
    .sound_a           (sound_a)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sa;
    logic        sc;
    logic [15:0] key;
    logic [15:0] alarm;
    logic [15:0] cur;
    logic [31:0] disp;
  } vec_t;

  typedef struct {
    logic        chk_disp;
    logic [31:0] disp;
    logic        snd;
    string       name;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are already driven; queue the expectation, clock once, compare.
  task automatic step(input logic chk_disp, input logic [31:0] disp, input logic snd, input string name);
    exp_t e;
    e.chk_disp = chk_disp;
    e.disp     = disp;
    e.snd      = snd;
    e.name     = name;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    if (e.chk_disp) chk({e.name, " display"}, display, e.disp);
    chk({e.name, " sound_a"}, {31'd0, sound_a}, {31'd0, e.snd});
  endtask

  task automatic idle_cycles(input int n, input logic snd, input string name);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, snd, name);
  endtask

  task automatic pulse_sec(input logic snd_after, input string name);
    one_second = 1'b1;
    step(1'b0, 32'd0, snd_after, name);
    one_second = 1'b0;
  endtask

  // Move the time off the alarm and back to it so the alarm re-arms and rings.
  task automatic rearm_ring(input string name);
    current_time = 16'h1231;
    step(1'b0, 32'd0, 1'b0, {name, " leave"});
    current_time = 16'h1230;
    step(1'b0, 32'd0, 1'b1, {name, " ring"});
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h1230, 16'h1159, 32'h31313539};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'h1230, 16'h1159, 32'h31323330};
    vecs[2] = '{1'b1, 1'b1, 16'hA905, 16'h1230, 16'h1159, 32'h45393035};
    vecs[3] = '{1'b0, 1'b1, 16'hFBC7, 16'h1230, 16'h1159, 32'h45454537};
    vecs[4] = '{1'b0, 1'b0, 16'hFBC7, 16'h1230, 16'h0987, 32'h30393837};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h9E01, 16'h0987, 32'h39453031};

    // Reset with times already matching
    reset             = 1'b1;
    one_second        = 1'b0;
    stop_alarm        = 1'b0;
    show_a            = 1'b0;
    show_current_time = 1'b0;
    key               = 16'h0000;
    alarm_time        = 16'h1230;
    current_time      = 16'h1230;
    @(negedge clock);
    @(negedge clock);
    chk("reset display", display, 32'h30303030);
    chk("reset sound_a", {31'd0, sound_a}, 32'd0);
    reset = 1'b0;
    step(1'b1, 32'h31323330, 1'b0, "post-reset match");
    idle_cycles(3, 1'b0, "post-reset no ring");

    // Display source select and encoding
    for (int i = 0; i < 6; i++) begin
      show_a            = vecs[i].sa;
      show_current_time = vecs[i].sc;
      key               = vecs[i].key;
      alarm_time        = vecs[i].alarm;
      current_time      = vecs[i].cur;
      step(1'b1, vecs[i].disp, 1'b0, $sformatf("vec%0d", i));
    end
    show_a            = 1'b0;
    show_current_time = 1'b0;

    // 12:29 -> 12:30 starts ringing one cycle later
    alarm_time   = 16'h1230;
    current_time = 16'h1229;
    idle_cycles(2, 1'b0, "pre-alarm");
    current_time = 16'h1230;
    step(1'b1, 32'h31323330, 1'b1, "alarm rise");
    idle_cycles(2, 1'b1, "ringing holds");

    // Timeout after three seconds, then hold until the minute changes
    pulse_sec(1'b1, "sec1");
    pulse_sec(1'b1, "sec2");
    pulse_sec(1'b0, "sec3 timeout");
    idle_cycles(4, 1'b0, "hold no re-ring");
    pulse_sec(1'b0, "sec in hold");
    rearm_ring("rearm1");

    // stop_alarm coincident with the final second
    pulse_sec(1'b1, "c sec1");
    pulse_sec(1'b1, "c sec2");
    stop_alarm = 1'b1;
    one_second = 1'b1;
    step(1'b0, 32'd0, 1'b0, "stop+timeout");
    stop_alarm = 1'b0;
    one_second = 1'b0;
    idle_cycles(3, 1'b0, "after stop");
    pulse_sec(1'b0, "after stop sec");

    // stop_alarm held across the rise goes straight to hold
    current_time = 16'h1231;
    step(1'b0, 32'd0, 1'b0, "leave2");
    current_time = 16'h1230;
    stop_alarm   = 1'b1;
    step(1'b0, 32'd0, 1'b0, "rise with stop");
    stop_alarm = 1'b0;
    idle_cycles(2, 1'b0, "rise with stop hold");

    // Alarm-time change also triggers ringing
    alarm_time = 16'h1245;
    step(1'b0, 32'd0, 1'b0, "alarm moved");
    alarm_time = 16'h1230;
    step(1'b0, 32'd0, 1'b1, "alarm-side rise");

    // Asynchronous reset mid-ring between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("async reset sound_a", {31'd0, sound_a}, 32'd0);
    chk("async reset display", display, 32'h30303030);
    reset = 1'b0;
    @(negedge clock);
    idle_cycles(3, 1'b0, "no ring after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
